// File: rtl/arb_pkg.sv
// Shared types for the round-robin quantum arbiter.
// Holds the FSM state enum and the expire-counter width.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int EXP_CNT_W = 16;

endpackage

// File: rtl/quantum_counter.sv
// W-bit grant-length counter: async reset, sync clear, increment,
// and an at_last flag that is high when count == q-1.
// Ports: clk, rst, clr, inc, q -> count, at_last.
module quantum_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] q,
  output logic [W-1:0] count,
  output logic         at_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // q is never 0 here, so q-1 cannot underflow
  assign at_last = (count == q - 1'b1);

endmodule

// File: rtl/rr_quantum_arbiter.sv
// Round-robin arbiter with a per-grant cycle quantum.
// Ports: i_clk, i_reset, i_req[R], i_quantum[W] -> o_grant[R],
// o_busy, o_count[W]; o_expire_cnt[16] when ARB_EXPIRE_CNT_EN is defined.
module rr_quantum_arbiter
  import arb_pkg::*;
#(
  parameter int R = 4,
  parameter int W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [R-1:0]         i_req,
  input  logic [W-1:0]         i_quantum,
  output logic [R-1:0]         o_grant,
  output logic                 o_busy,
`ifdef ARB_EXPIRE_CNT_EN
  output logic [EXP_CNT_W-1:0] o_expire_cnt,
`endif
  output logic [W-1:0]         o_count
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;

  // First set request scanning last+1 .. last (mod R)
  function automatic logic [LW-1:0] rr_pick(
    input logic [R-1:0]  req,
    input logic [LW-1:0] last_i
  );
    logic [LW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last_i;
    found = 1'b0;
    for (int i = 1; i <= R; i++) begin
      idx = (int'(last_i) + i) % R;
      if (!found && req[idx]) begin
        pick  = LW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_t        state;
  logic [LW-1:0] last;
  logic [W-1:0]  q;
  logic [R-1:0]  grant;
  logic [W-1:0]  count;
  logic          at_last;
  logic          any_req;
  logic          owner_req;
  logic          grant_end;
  logic          start;
  logic          in_grant;
  logic [LW-1:0] winner;
  logic [W-1:0]  q_new;

  assign in_grant  = (state == ST_GRANT);
  assign any_req   = |i_req;
  assign owner_req = i_req[last];
  assign grant_end = in_grant && (!owner_req || at_last);
  assign start     = any_req && (!in_grant || grant_end);
  assign winner    = rr_pick(i_req, last);
  assign q_new     = (i_quantum == '0) ? W'(1) : i_quantum;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      last  <= LW'(R - 1);
      q     <= W'(1);
      grant <= '0;
    end else if (start) begin
      state <= ST_GRANT;
      last  <= winner;
      q     <= q_new;
      grant <= {{(R-1){1'b0}}, 1'b1} << winner;
    end else if (grant_end) begin
      state <= ST_IDLE;
      grant <= '0;
    end
  end

  // Any grant end either starts a fresh grant or goes idle: both zero
  quantum_counter #(.W(W)) u_cnt (
    .clk     (i_clk),
    .rst     (i_reset),
    .clr     (!in_grant || grant_end),
    .inc     (1'b1),
    .q       (q),
    .count   (count),
    .at_last (at_last)
  );

  assign o_grant = grant;
  assign o_busy  = |grant;
  assign o_count = count;

`ifdef ARB_EXPIRE_CNT_EN
  logic expire;
  // Expiry only: owner still requesting when the quantum runs out
  assign expire = in_grant && owner_req && at_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_expire_cnt <= '0;
    end else if (expire && (o_expire_cnt != '1)) begin
      o_expire_cnt <= o_expire_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// Directed scoreboard bench for rr_quantum_arbiter (R=4, W=8).
// Expected grant/count pairs are queued before each clock and checked after it.
module tb_rr_quantum_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] quantum;
  logic [3:0] grant;
  logic       busy;
  logic [7:0] count;
`ifdef ARB_EXPIRE_CNT_EN
  logic [15:0] expire_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] g;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];

  rr_quantum_arbiter #(.R(4), .W(8)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req        (req),
    .i_quantum    (quantum),
    .o_grant      (grant),
    .o_busy       (busy),
`ifdef ARB_EXPIRE_CNT_EN
    .o_expire_cnt (expire_cnt),
`endif
    .o_count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] c);
    exp_t e;
    e.g = g;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s scoreboard empty observed=%0h", tag, grant);
    end else begin
      e = sb.pop_front();
      chk({tag, "_grant"}, 32'(grant), 32'(e.g));
      chk({tag, "_count"}, 32'(count), 32'(e.c));
      chk({tag, "_busy"}, 32'(busy), 32'(e.g != 4'b0));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0;
    quantum = 8'd0;
    #12;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // single requester, quantum 3: continuous re-grant
    quantum = 8'd3;
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      push(4'b0001, 8'(k % 3));
      tick("s1");
    end
    req = 4'b0000;
    push(4'b0000, 8'd0);
    tick("s1_idle");

    // all requesting, quantum 2, from reset
    rst = 1'b1;
    quantum = 8'd2;
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push(4'b0001 << ((k / 2) % 4), 8'(k % 2));
      tick("s2");
    end
    req = 4'b0000;
    push(4'b0000, 8'd0);
    tick("s2_idle");

    // early release handover; quantum change applies only at next grant
    do_reset();
    quantum = 8'd10;
    req = 4'b0011;
    push(4'b0001, 8'd0);
    tick("s3");
    quantum = 8'd1;
    for (int k = 1; k < 4; k++) begin
      push(4'b0001, 8'(k));
      tick("s3");
    end
    req = 4'b0010;
    push(4'b0010, 8'd0);
    tick("s3_handover");
    push(4'b0010, 8'd0);
    tick("s3_q1");
    req = 4'b0000;
    push(4'b0000, 8'd0);
    tick("s3_idle");

    // quantum 0 acts as 1; last owner was 1 so requester 2 goes first
    quantum = 8'd0;
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      push((k % 2 == 0) ? 4'b0100 : 4'b0001, 8'd0);
      tick("s4");
    end
    req = 4'b0000;
    push(4'b0000, 8'd0);
    tick("s4_idle");

    // reset mid-grant drops the grant without a clock edge
    quantum = 8'd10;
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      push(4'b0001, 8'(k));
      tick("s5");
    end
    #2;
    rst = 1'b1;
    #1;
    chk("s5_async_grant", 32'(grant), 32'h0);
    chk("s5_async_busy", 32'(busy), 32'h0);
    chk("s5_async_count", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    chk("s5_hold_grant", 32'(grant), 32'h0);
    req = 4'b1000;
    @(negedge clk);
    rst = 1'b0;
    push(4'b1000, 8'd0);
    tick("s5_after");
    req = 4'b0000;
    push(4'b0000, 8'd0);
    tick("s5_idle");

`ifdef ARB_EXPIRE_CNT_EN
    do_reset();
    chk("s6_rst_cnt", 32'(expire_cnt), 32'h0);
    quantum = 8'd2;
    req = 4'b0011;
    for (int k = 0; k < 21; k++) begin
      push(4'b0001 << ((k / 2) % 2), 8'(k % 2));
      tick("s6");
    end
    chk("s6_expire_cnt", 32'(expire_cnt), 32'd10);
    req = 4'b0010;
    push(4'b0010, 8'd0);
    tick("s6_release");
    chk("s6_release_cnt", 32'(expire_cnt), 32'd10);
    req = 4'b0000;
    push(4'b0000, 8'd0);
    tick("s6_idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
